// File: rtl/aes_pkg.sv
// Shared AES types, round count, controller step encoding and GF(2^8) helpers
// used by the per-step datapath modules.
package aes_pkg;

  typedef logic [15:0][7:0] state_t;

  localparam int AES_NR = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUB,
    ST_SHIFT,
    ST_MIX,
    ST_KEY,
    ST_DONE
  } round_step_e;

  // The first plaintext byte sits in the top byte lane; bytes fill the 4x4
  // state column by column, so row r of column c lives at lane 15 - (r + 4c).
  function automatic logic [3:0] byte_pos(input int r, input int c);
    return 4'(15 - r - 4 * c);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // S-box built arithmetically: multiplicative inverse as a^254, then the
  // affine map. The zero input falls out as zero before the affine step.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake, data and round-key request bundle between the I/O wrapper /
// key schedule (master side) and the round controller (slave side).
interface aes_round_ctrl_if;
  import aes_pkg::*;

  logic       start;
  logic       abort;
  state_t     pt;
  logic       ready;
  logic       done;
  state_t     ct;
  logic [3:0] rk_idx;
  state_t     rk;

  modport master (
    output start, abort, pt, rk,
    input  ready, done, ct, rk_idx
  );

  modport slave (
    input  start, abort, pt, rk,
    output ready, done, ct, rk_idx
  );

endinterface

// File: rtl/aes_step_datapath.sv
// Combinational next-value selector for the cipher state: one AES step,
// chosen by the controller's current FSM step.
module aes_step_datapath
  import aes_pkg::*;
(
  input  round_step_e step,
  input  state_t      data,
  input  state_t      pt,
  input  state_t      rk,
  output state_t      data_next
);

  state_t sub_out;
  state_t shift_out;
  state_t mix_out;

  subbytes   u_subbytes   (.state(data), .result(sub_out));
  shiftrows  u_shiftrows  (.state(data), .result(shift_out));
  mixcolumns u_mixcolumns (.state(data), .result(mix_out));

  // IDLE computes the initial whitening so the load edge needs no extra step.
  always_comb begin
    case (step)
      ST_IDLE:  data_next = pt ^ rk;
      ST_SUB:   data_next = sub_out;
      ST_SHIFT: data_next = shift_out;
      ST_MIX:   data_next = mix_out;
      ST_KEY:   data_next = data ^ rk;
      default:  data_next = data;
    endcase
  end

endmodule

// File: rtl/mixcolumns.sv
// Column mixing with the fixed {02,03,01,01} circulant matrix.
module mixcolumns
  import aes_pkg::*;
(
  input  state_t state,
  output state_t result
);

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    result = '0;
    a0 = 8'h00;
    a1 = 8'h00;
    a2 = 8'h00;
    a3 = 8'h00;
    for (int c = 0; c < 4; c++) begin
      a0 = state[byte_pos(0, c)];
      a1 = state[byte_pos(1, c)];
      a2 = state[byte_pos(2, c)];
      a3 = state[byte_pos(3, c)];
      result[byte_pos(0, c)] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      result[byte_pos(1, c)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      result[byte_pos(2, c)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      result[byte_pos(3, c)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

endmodule

// File: rtl/shiftrows.sv
// Cyclic left shift of row r by r positions.
module shiftrows
  import aes_pkg::*;
(
  input  state_t state,
  output state_t result
);

  always_comb begin
    result = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        result[byte_pos(r, c)] = state[byte_pos(r, (c + r) % 4)];
      end
    end
  end

endmodule

// File: rtl/subbytes.sv
// Byte-wise AES S-box substitution over the whole state.
module subbytes
  import aes_pkg::*;
(
  input  state_t state,
  output state_t result
);

  always_comb begin
    result = '0;
    for (int i = 0; i < 16; i++) result[4'(i)] = sbox(state[4'(i)]);
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round controller: FSM, round counter and cipher state
// register, advancing one transformation step per clock.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic           clk,
  input  logic           reset,
  aes_round_ctrl_if.slave bus
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  round_step_e step;
  round_step_e step_next;
  logic [3:0]  round;
  state_t      data_q;
  state_t      data_next;
  logic        accept;
  logic        advance;

  assign accept  = (step == ST_IDLE) && bus.start && !bus.abort;
  assign advance = (step inside {ST_SUB, ST_SHIFT, ST_MIX, ST_KEY}) && !bus.abort;

  aes_step_datapath u_datapath (
    .step      (step),
    .data      (data_q),
    .pt        (bus.pt),
    .rk        (bus.rk),
    .data_next (data_next)
  );

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) step <= ST_IDLE;
    else       step <= step_next;
  end

  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    step_next = step;
    case (step)
      ST_IDLE:  if (bus.start) step_next = ST_SUB;
      ST_SUB:   step_next = ST_SHIFT;
      ST_SHIFT: step_next = (round == LAST_ROUND) ? ST_KEY : ST_MIX;
      ST_MIX:   step_next = ST_KEY;
      ST_KEY:   step_next = (round == LAST_ROUND) ? ST_DONE : ST_SUB;
      ST_DONE:  step_next = ST_IDLE;
      default:  step_next = ST_IDLE;
    endcase
    // Abort cancels from any step; in IDLE it also masks start.
    if (bus.abort) step_next = ST_IDLE;
  end

  always_comb begin
    bus.ready  = (step == ST_IDLE);
    bus.done   = (step == ST_DONE);
    bus.rk_idx = (step == ST_KEY) ? round : 4'd0;
  end

  assign bus.ct = data_q;

  // An abort freezes both the partial state and the round count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round  <= 4'd0;
      data_q <= '0;
    end else begin
      if (accept || advance) data_q <= data_next;
      if (accept) round <= 4'd1;
      else if (advance && step == ST_KEY && round != LAST_ROUND) round <= round + 4'd1;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: FIPS-197 vectors, random vectors
// against a byte-level reference model, and multi-cycle corner sequences.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  typedef logic [7:0] bytes_t [0:15];
  typedef state_t rk_arr_t [0:10];
  typedef struct {
    string  name;
    state_t key;
    state_t pt;
    state_t ct;
  } vec_t;

  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam state_t KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam state_t PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam state_t CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam state_t KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam state_t PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam state_t CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  rk_arr_t rks;
  int      done_e[$];
  state_t  done_ct[$];
  int      idx_tr[$];
  int      ready_tr[$];

  aes_round_ctrl_if bus ();

  aes_round_ctrl #(.NR(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Key-schedule block model: answers the requested index combinationally.
  always_comb bus.rk = (bus.rk_idx <= 4'd10) ? rks[bus.rk_idx] : '0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic bytes_t to_bytes(input state_t s);
    bytes_t b;
    for (int i = 0; i < 16; i++) b[i] = s[15 - i];
    return b;
  endfunction

  function automatic state_t from_bytes(input bytes_t b);
    state_t s;
    for (int i = 0; i < 16; i++) s[15 - i] = b[i];
    return s;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int acc = 0;
    int x   = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11b;
    end
    return 8'(acc);
  endfunction

  function automatic rk_arr_t expand(input state_t key);
    rk_arr_t     out;
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    logic [127:0] k;
    k    = key;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SBOX_TBL[t[31:24]], SBOX_TBL[t[23:16]], SBOX_TBL[t[15:8]], SBOX_TBL[t[7:0]]};
        t = t ^ {rcon, 24'h000000};
        rcon = rcon[7] ? ({rcon[6:0], 1'b0} ^ 8'h1b) : {rcon[6:0], 1'b0};
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r <= 10; r++) out[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    return out;
  endfunction

  function automatic state_t aes_ref(input state_t key, input state_t p);
    rk_arr_t k;
    bytes_t  s;
    bytes_t  t;
    k = expand(key);
    s = to_bytes(p ^ k[0]);
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = SBOX_TBL[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r + 4 * c] = s[r + 4 * ((c + r) % 4)];
      s = t;
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            t[r + 4 * c] = gmul(8'h02, s[4 * c + r]) ^ gmul(8'h03, s[4 * c + (r + 1) % 4]) ^
                           s[4 * c + (r + 2) % 4] ^ s[4 * c + (r + 3) % 4];
        s = t;
      end
      s = to_bytes(from_bytes(s) ^ k[rnd]);
    end
    return from_bytes(s);
  endfunction

  // Starts an encryption of p at the next edge (E0) and watches ncyc cycles.
  // Trace entry e holds the outputs seen in the cycle after edge Ee.
  task automatic run_op(input state_t p, input state_t alt, input int alt_from,
                        input int start_until, input int busy_at, input int abort_at,
                        input int reset_at, input int ncyc);
    done_e.delete();
    done_ct.delete();
    idx_tr.delete();
    ready_tr.delete();
    bus.pt    = p;
    bus.start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      idx_tr.push_back(int'(bus.rk_idx));
      ready_tr.push_back(int'(bus.ready));
      if (bus.done === 1'b1) begin
        done_e.push_back(k - 1);
        done_ct.push_back(bus.ct);
      end
      if (k == reset_at + 1) reset = 1'b0;
      bus.start = (k < start_until) || (k == busy_at);
      bus.pt    = (k >= alt_from) ? alt : p;
      bus.abort = (k == abort_at);
      if (k == reset_at) begin
        #2 reset = 1'b1;
        #1;
        check("reset_async_ready", bus.ready, 1);
        check("reset_async_ct", bus.ct, 0);
        check("reset_async_done", bus.done, 0);
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    vec_t   vecs [8];
    int     exp_idx[$];
    state_t alt_pt;
    state_t alt_ct;

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.pt    = '0;
    rks       = expand('0);

    vecs[0] = '{"fips_b", KEY_B, PT_B, CT_B};
    vecs[1] = '{"fips_c1", KEY_C, PT_C, CT_C};
    for (int i = 2; i < 8; i++) begin
      vecs[i].name = $sformatf("random_%0d", i);
      vecs[i].key  = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].pt   = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].ct   = aes_ref(vecs[i].key, vecs[i].pt);
    end

    // Expected key-index schedule: rounds 1..9 are SUB,SHIFT,MIX,KEY; round 10
    // drops MIX; then one DONE cycle and an idle cycle.
    for (int r = 1; r <= 10; r++) begin
      exp_idx.push_back(0);
      exp_idx.push_back(0);
      if (r < 10) exp_idx.push_back(0);
      exp_idx.push_back(r);
    end
    exp_idx.push_back(0);
    exp_idx.push_back(0);

    #1 reset = 1'b1;
    #1;
    check("reset_ready", bus.ready, 1);
    check("reset_done", bus.done, 0);
    check("reset_ct", bus.ct, 0);
    check("reset_rk_idx", bus.rk_idx, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", bus.ready, 1);

    foreach (vecs[i]) begin
      rks = expand(vecs[i].key);
      run_op(vecs[i].pt, '0, 1000, 1, -1, -1, -1, 45);
      check({vecs[i].name, "_done_count"}, done_e.size(), 1);
      if (done_e.size() > 0) begin
        check({vecs[i].name, "_latency"}, done_e[0], 39);
        check({vecs[i].name, "_ct_at_done"}, done_ct[0], vecs[i].ct);
      end
      check({vecs[i].name, "_ready_in_done"}, ready_tr[39], 0);
      check({vecs[i].name, "_ready_after_done"}, ready_tr[40], 1);
      check({vecs[i].name, "_ct_held"}, bus.ct, vecs[i].ct);
      if (i == 1) begin
        for (int e = 0; e <= 40; e++)
          check($sformatf("rk_idx_e%0d", e), idx_tr[e], exp_idx[e]);
      end
    end

    // Start pulse with different plaintext while busy must be ignored.
    rks = expand(KEY_B);
    run_op(PT_B, PT_C, 10, 1, 10, -1, -1, 45);
    check("busy_start_done_count", done_e.size(), 1);
    if (done_e.size() > 0) check("busy_start_ct", done_ct[0], CT_B);

    // Abort mid-run, then a clean rerun.
    run_op(PT_B, '0, 1000, 1, -1, 20, -1, 45);
    check("abort_no_done", done_e.size(), 0);
    check("abort_busy_before", ready_tr[19], 0);
    check("abort_ready_next", ready_tr[20], 1);
    run_op(PT_B, '0, 1000, 1, -1, -1, -1, 45);
    check("after_abort_done_count", done_e.size(), 1);
    if (done_e.size() > 0) check("after_abort_ct", done_ct[0], CT_B);

    // Abort and start together in IDLE: abort wins.
    bus.pt    = PT_C;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    check("abort_start_idle_ready", bus.ready, 1);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_start_idle_ready2", bus.ready, 1);
    check("abort_start_idle_ct", bus.ct, CT_B);

    // Asynchronous reset mid-run: no done, state cleared.
    rks = expand(KEY_C);
    run_op(PT_C, '0, 1000, 1, -1, -1, 15, 50);
    check("reset_run_no_done", done_e.size(), 0);
    check("reset_run_ct_zero", bus.ct, 0);
    check("reset_run_ready", bus.ready, 1);

    // Back-to-back: start held until accepted in the first ready cycle.
    rks    = expand(KEY_B);
    alt_pt = {$urandom, $urandom, $urandom, $urandom};
    alt_ct = aes_ref(KEY_B, alt_pt);
    run_op(PT_B, alt_pt, 1, 42, -1, -1, -1, 85);
    check("b2b_done_count", done_e.size(), 2);
    check("b2b_first_ready", ready_tr[40], 1);
    if (done_e.size() == 2) begin
      check("b2b_first_latency", done_e[0], 39);
      check("b2b_spacing", done_e[1] - done_e[0], 41);
      check("b2b_first_ct", done_ct[0], CT_B);
      check("b2b_second_ct", done_ct[1], alt_ct);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
